// File: rtl/pipe_seq_ctrl_if.sv
// pipe_seq_ctrl_if: bundles the decode/execute hazard inputs and the
// pipeline control outputs of pipe_seq_ctrl.
//   master : pipeline side (drives decode/execute info, receives controls)
//   slave  : pipe_seq_ctrl side
// Optional macro HAZ_STATS_EN adds the stall_cnt / flush_cnt statistics.
interface pipe_seq_ctrl_if;
  logic [15:0] id_ir;
  logic [2:0]  id_src1;
  logic [2:0]  id_src2;
  logic        id_use1;
  logic        id_use2;
  logic        ex_load;
  logic [2:0]  ex_dest;
  logic        br_taken;

  logic        hold_pc;
  logic        hold_ifid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        mult_active;
  logic        first_multiple;
  logic        mult_last;
  logic [2:0]  mult_reg;

`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_ir, id_src1, id_src2, id_use1, id_use2, ex_load, ex_dest, br_taken,
    input  hold_pc, hold_ifid, flush_ifid, flush_idex,
    input  mult_active, first_multiple, mult_last, mult_reg,
    input  stall_cnt, flush_cnt
  );
  modport slave (
    input  id_ir, id_src1, id_src2, id_use1, id_use2, ex_load, ex_dest, br_taken,
    output hold_pc, hold_ifid, flush_ifid, flush_idex,
    output mult_active, first_multiple, mult_last, mult_reg,
    output stall_cnt, flush_cnt
  );
`else
  modport master (
    output id_ir, id_src1, id_src2, id_use1, id_use2, ex_load, ex_dest, br_taken,
    input  hold_pc, hold_ifid, flush_ifid, flush_idex,
    input  mult_active, first_multiple, mult_last, mult_reg
  );
  modport slave (
    input  id_ir, id_src1, id_src2, id_use1, id_use2, ex_load, ex_dest, br_taken,
    output hold_pc, hold_ifid, flush_ifid, flush_idex,
    output mult_active, first_multiple, mult_last, mult_reg
  );
`endif
endinterface

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: pipeline hazard controller. Resolves taken branches
// (flush), load-use hazards (stall one cycle) and sequences LM/SM
// multi-register instructions into one micro-op per listed register.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : pipe_seq_ctrl_if.slave (decode/execute inputs, control outputs)
// Optional macro HAZ_STATS_EN adds saturating stall_cnt / flush_cnt.
//
// state | meaning
// IDLE  | no multi-register sequence in progress; decode inspected directly
// MULTI | LM/SM in progress; remaining registers held in mask
module pipe_seq_ctrl (
  input logic         clk,
  input logic         reset,
  pipe_seq_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MULTI = 1'b1;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  logic [0:0] state, stateNext;
  // Remaining list bits [7:1]; bit 0 can never remain after the first issue.
  logic [6:0] mask, maskNext;

  logic       loadUse, isLmSm, seqActive, lastOp;
  logic [7:0] curList, remList;
  logic [2:0] lowIdx;
  logic       holdPc, holdIfid, flushIfid, flushIdex;
  logic       multActive, firstMultiple, multLast;
  logic [2:0] multReg;
  logic       unusedIrBits;

  assign unusedIrBits = ^bus.id_ir[11:8];

  function automatic logic [2:0] lowestIdx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    loadUse = bus.ex_load &&
              ((bus.id_use1 && (bus.id_src1 == bus.ex_dest)) ||
               (bus.id_use2 && (bus.id_src2 == bus.ex_dest)));
    isLmSm    = (bus.id_ir[15:12] == OP_LM) || (bus.id_ir[15:12] == OP_SM);
    curList   = (state == MULTI) ? {mask, 1'b0} : bus.id_ir[7:0];
    seqActive = (state == MULTI) || (isLmSm && (bus.id_ir[7:0] != 8'd0));
    lowIdx    = lowestIdx(curList);
    remList   = curList & (curList - 8'd1);
    lastOp    = (remList == 8'd0);

    holdPc        = 1'b0;
    holdIfid      = 1'b0;
    flushIfid     = 1'b0;
    flushIdex     = 1'b0;
    multActive    = 1'b0;
    firstMultiple = 1'b0;
    multLast      = 1'b0;
    multReg       = 3'd0;
    stateNext     = state;
    maskNext      = mask;

    if (bus.br_taken) begin
      flushIfid = 1'b1;
      flushIdex = 1'b1;
      stateNext = IDLE;
      maskNext  = 7'd0;
    end else if (loadUse) begin
      // Stall: state and mask frozen so the sequence resumes afterwards.
      holdPc    = 1'b1;
      holdIfid  = 1'b1;
      flushIdex = 1'b1;
    end else if (seqActive) begin
      multActive    = 1'b1;
      firstMultiple = (state == IDLE);
      multLast      = lastOp;
      multReg       = lowIdx;
      holdPc        = !lastOp;
      holdIfid      = !lastOp;
      maskNext      = remList[7:1];
      stateNext     = lastOp ? IDLE : MULTI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mask  <= 7'd0;
    end else begin
      state <= stateNext;
      mask  <= maskNext;
    end
  end

  assign bus.hold_pc        = holdPc;
  assign bus.hold_ifid      = holdIfid;
  assign bus.flush_ifid     = flushIfid;
  assign bus.flush_idex     = flushIdex;
  assign bus.mult_active    = multActive;
  assign bus.first_multiple = firstMultiple;
  assign bus.mult_last      = multLast;
  assign bus.mult_reg       = multReg;

`ifdef HAZ_STATS_EN
  logic [15:0] stallCnt, flushCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= 16'd0;
      flushCnt <= 16'd0;
    end else begin
      if (holdPc && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
      if (flushIfid && (flushCnt != 16'hFFFF)) flushCnt <= flushCnt + 16'd1;
    end
  end

  assign bus.stall_cnt = stallCnt;
  assign bus.flush_cnt = flushCnt;
`endif
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   passes;

  pipe_seq_ctrl_if bus ();

  pipe_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output vector: {hold_pc, hold_ifid, flush_ifid, flush_idex,
  //                 mult_active, first_multiple, mult_last, mult_reg[2:0]}
  function automatic logic [9:0] mk(bit hp, bit hi, bit fi, bit fe,
                                    bit ma, bit fm, bit ml, int rg);
    return {hp, hi, fi, fe, ma, fm, ml, 3'(rg)};
  endfunction

  function automatic logic [9:0] outVec();
    return {bus.hold_pc, bus.hold_ifid, bus.flush_ifid, bus.flush_idex,
            bus.mult_active, bus.first_multiple, bus.mult_last, bus.mult_reg};
  endfunction

  task automatic setIn(input logic [15:0] ir, input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic ld,
                       input logic [2:0] dst, input logic br);
    bus.id_ir = ir; bus.id_src1 = s1; bus.id_src2 = s2;
    bus.id_use1 = u1; bus.id_use2 = u2; bus.ex_load = ld;
    bus.ex_dest = dst; bus.br_taken = br;
  endtask

  // Samples mid-cycle, compares, then advances past the next rising edge.
  task automatic checkOut(input string name, input logic [9:0] exp);
    logic [9:0] got;
    #3;
    got = outVec();
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b expected %b (hp hi fi fe ma fm ml reg)", name, got, exp);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    setIn(16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic        u1;
    logic        u2;
    logic        ld;
    logic [2:0]  dst;
    logic        br;
    logic [9:0]  exp;
  } vec_t;

  vec_t vecs[13];

  // Reference model state: registers still to be issued for the current LM/SM.
  int   q[$];
`ifdef HAZ_STATS_EN
  int   stallM, flushM;
`endif

  initial begin
    logic [9:0] e;
    logic [15:0] ir;
    logic [2:0] s1, s2, dst;
    logic u1, u2, ld, br, lu, last;
    int r;

    checks = 0; passes = 0;
    clk = 1'b0;
    reset = 1'b1;
    setIn(16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    vecs[0]  = '{16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mk(0,0,0,0,0,0,0,0)};
    vecs[1]  = '{16'h1234, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, mk(1,1,0,1,0,0,0,0)};
    vecs[2]  = '{16'h1234, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, mk(1,1,0,1,0,0,0,0)};
    vecs[3]  = '{16'h1234, 3'd5, 3'd5, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, mk(0,0,0,0,0,0,0,0)};
    vecs[4]  = '{16'h1234, 3'd5, 3'd5, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0, mk(0,0,0,0,0,0,0,0)};
    vecs[5]  = '{16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, mk(0,0,1,1,0,0,0,0)};
    vecs[6]  = '{16'h0000, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, mk(0,0,1,1,0,0,0,0)};
    vecs[7]  = '{16'h60A5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mk(1,1,0,0,1,1,0,0)};
    vecs[8]  = '{16'h7080, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mk(0,0,0,0,1,1,1,7)};
    vecs[9]  = '{16'h6000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mk(0,0,0,0,0,0,0,0)};
    vecs[10] = '{16'h50FF, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mk(0,0,0,0,0,0,0,0)};
    vecs[11] = '{16'h603C, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, mk(1,1,0,1,0,0,0,0)};
    vecs[12] = '{16'h703C, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, mk(0,0,1,1,0,0,0,0)};

    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    checkOut("reset_state", mk(0,0,0,0,0,0,0,0));

    for (int i = 0; i < 13; i++) begin
      doReset();
      setIn(vecs[i].ir, vecs[i].s1, vecs[i].s2, vecs[i].u1, vecs[i].u2,
            vecs[i].ld, vecs[i].dst, vecs[i].br);
      checkOut($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Single-cycle load-use stall.
    doReset();
    setIn(16'h1000, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    checkOut("lu_cycle", mk(1,1,0,1,0,0,0,0));
    setIn(16'h1000, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    checkOut("lu_after", mk(0,0,0,0,0,0,0,0));

    // LM 0xA5 -> registers 0,2,5,7.
    doReset();
    setIn(16'h60A5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOut("lm_a5_op0", mk(1,1,0,0,1,1,0,0));
    checkOut("lm_a5_op1", mk(1,1,0,0,1,0,0,2));
    checkOut("lm_a5_op2", mk(1,1,0,0,1,0,0,5));
    checkOut("lm_a5_op3", mk(0,0,0,0,1,0,1,7));
    setIn(16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOut("lm_a5_done", mk(0,0,0,0,0,0,0,0));

    // SM 0x3C aborted by a taken branch on the second micro-op.
    doReset();
    setIn(16'h703C, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOut("sm_3c_op0", mk(1,1,0,0,1,1,0,2));
    bus.br_taken = 1'b1;
    checkOut("sm_3c_br", mk(0,0,1,1,0,0,0,0));
    setIn(16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOut("sm_3c_idle", mk(0,0,0,0,0,0,0,0));

    // Load-use in MULTI stalls without advancing the mask.
    doReset();
    setIn(16'h60A5, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
    checkOut("stall_op0", mk(1,1,0,0,1,1,0,0));
    bus.ex_load = 1'b1;
    checkOut("stall_lu", mk(1,1,0,1,0,0,0,0));
    bus.ex_load = 1'b0;
    checkOut("stall_op1", mk(1,1,0,0,1,0,0,2));

    // Reset in the middle of LM 0xFF, then a clean restart.
    doReset();
    setIn(16'h60FF, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOut("ff_op0", mk(1,1,0,0,1,1,0,0));
    checkOut("ff_op1", mk(1,1,0,0,1,0,0,1));
    reset = 1'b1;
    checkOut("ff_op2", mk(1,1,0,0,1,0,0,2));
    reset = 1'b0;
    setIn(16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOut("ff_after_reset", mk(0,0,0,0,0,0,0,0));
    bus.id_ir = 16'h6081;
    checkOut("restart_op0", mk(1,1,0,0,1,1,0,0));
    checkOut("restart_op1", mk(0,0,0,0,1,0,1,7));

    // Randomized run against the register-queue model.
    doReset();
    q.delete();
`ifdef HAZ_STATS_EN
    stallM = 0; flushM = 0;
`endif
    ir = 16'h0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: ir[15:12] = 4'h6;
          1: ir[15:12] = 4'h7;
          default: ir[15:12] = 4'($urandom_range(0, 15));
        endcase
        ir[11:8] = 4'($urandom_range(0, 15));
        ir[7:0]  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      end
      s1  = 3'($urandom_range(0, 7));
      s2  = 3'($urandom_range(0, 7));
      dst = 3'($urandom_range(0, 7));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      setIn(ir, s1, s2, u1, u2, ld, dst, br);

      lu = ld && ((u1 && (s1 == dst)) || (u2 && (s2 == dst)));
      if (br) begin
        e = mk(0,0,1,1,0,0,0,0);
        q.delete();
      end else if (lu) begin
        e = mk(1,1,0,1,0,0,0,0);
      end else if (q.size() > 0) begin
        r = q.pop_front();
        last = (q.size() == 0);
        e = mk(!last, !last, 0, 0, 1, 0, last, r);
      end else if ((ir[15:12] == 4'h6 || ir[15:12] == 4'h7) && ir[7:0] != 8'h00) begin
        for (int b = 0; b < 8; b++) if (ir[b]) q.push_back(b);
        r = q.pop_front();
        last = (q.size() == 0);
        e = mk(!last, !last, 0, 0, 1, 1, last, r);
      end else begin
        e = mk(0,0,0,0,0,0,0,0);
      end
`ifdef HAZ_STATS_EN
      if (e[9]) stallM++;
      if (e[7]) flushM++;
`endif
      checkOut("random", e);
    end

`ifdef HAZ_STATS_EN
    checks++;
    if (bus.stall_cnt === 16'(stallM)) passes++;
    else $display("FAIL stall_cnt: got %0d expected %0d", bus.stall_cnt, stallM);
    checks++;
    if (bus.flush_cnt === 16'(flushM)) passes++;
    else $display("FAIL flush_cnt: got %0d expected %0d", bus.flush_cnt, flushM);

    doReset();
    setIn(16'h1000, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (bus.stall_cnt === 16'hFFFF) passes++;
    else $display("FAIL stall_sat: got %h expected ffff", bus.stall_cnt);
    checks++;
    if (bus.flush_cnt === 16'h0000) passes++;
    else $display("FAIL flush_idle: got %h expected 0000", bus.flush_cnt);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port id_ir, input, 16 bits: instruction in decode; opcode = id_ir[15:12], register list = id_ir[7:0].
REQ-004 The block SHALL have the ports id_src1, id_src2, input, 3 bits each, and id_use1, id_use2, input, 1 bit each: decode source registers and their valid flags.
REQ-005 The block SHALL have the ports ex_load, input, 1 bit, and ex_dest, input, 3 bits: execute-stage instruction is a load, and its destination register.
REQ-006 The block SHALL have the port br_taken, input, 1 bit: branch or jump resolved taken in execute this cycle.
REQ-007 The block SHALL have the ports hold_pc and hold_ifid, output, 1 bit each: freeze the PC and the IF/ID register.
REQ-008 The block SHALL have the ports flush_ifid and flush_idex, output, 1 bit each: insert a NOP into the IF/ID or ID/EX register.
REQ-009 The block SHALL have the ports mult_active, first_multiple and mult_last, output, 1 bit each, and mult_reg, output, 3 bits: LM/SM micro-op control.

Function
REQ-010 Priority SHALL be br_taken, then load-use, then LM/SM sequencing, then idle; hold and flush outputs are combinational from inputs and state.
REQ-011 On br_taken=1, flush_ifid=1 and flush_idex=1; hold_pc=0 and hold_ifid=0; an active LM/SM sequence aborts and the FSM returns to IDLE next edge.
REQ-012 Load-use SHALL be ex_load=1 and ((id_use1 and id_src1==ex_dest) or (id_use2 and id_src2==ex_dest)).
REQ-013 On load-use without br_taken: hold_pc=1, hold_ifid=1 and flush_idex=1 for exactly that cycle; FSM state is unchanged.
REQ-014 FSM states SHALL be IDLE and MULTI, with a 7-bit registered remaining mask; LM opcode = 4'b0110, SM opcode = 4'b0111.
REQ-015 In IDLE, when decode holds LM/SM with list L != 0 and no higher-priority event: mult_active=1, first_multiple=1, mult_reg=index of the lowest set bit of L, and mult_last=(L has exactly one bit set).
REQ-016 In the REQ-015 case, hold_pc=hold_ifid=!mult_last; the mask loads L with its lowest set bit cleared, and the FSM moves to MULTI if that mask is nonzero.
REQ-017 In MULTI: mult_active=1, first_multiple=0, mult_reg=index of the lowest set bit of the mask, and mult_last=(mask has exactly one bit set); hold_pc=hold_ifid=!mult_last.
REQ-018 In MULTI, each cycle clears the lowest mask bit; after mult_last the FSM returns to IDLE.
REQ-019 An LM/SM with k set bits SHALL occupy decode for exactly k cycles; L==0 SHALL be treated as a NOP with no hold and mult_active=0.
REQ-020 Load-use in MULTI SHALL stall the sequence: the mask is not advanced and mult_active is 0 that cycle.
REQ-021 In IDLE with no event, all control outputs SHALL be 0 and mult_reg SHALL be 3'd0.

Reset
REQ-022 reset=1 at a clock edge SHALL force IDLE and mask=0, including mid-sequence; all outputs then read 0 until new stimulus.
REQ-023 reset SHALL take priority over every other input.

Configuration
REQ-024 With HAZ_STATS_EN defined: add stall_cnt and flush_cnt, output, 16 bits each, both saturating at 16'hFFFF and cleared by reset.
REQ-025 With HAZ_STATS_EN defined: stall_cnt increments on each cycle with hold_pc=1, and flush_cnt increments on each cycle with flush_ifid=1.
REQ-026 Without HAZ_STATS_EN, those ports and counters SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-027 ex_load=1, ex_dest=3, id_src1=3, id_use1=1 for one cycle -> hold_pc=hold_ifid=flush_idex=1 for exactly one cycle, then 0.
REQ-028 id_ir=16'h6_0_A5 (LM, L=8'hA5) -> mult_reg=0,2,5,7 on consecutive cycles; first_multiple only on the first; mult_last only on the fourth; hold_pc=1 for three cycles.
REQ-029 SM with L=8'h3C, br_taken=1 on the second micro-op -> flush_ifid=flush_idex=1 that cycle, and IDLE next cycle with mult_active=0.
REQ-030 LM with L=8'h00 -> no hold and mult_active=0; a single-bit L=8'h80 -> one cycle with mult_reg=7, first_multiple=1, mult_last=1, hold_pc=0.
REQ-031 reset=1 asserted during the third micro-op of L=8'hFF -> all outputs 0 on the next cycle; a new LM starts cleanly with first_multiple=1.
REQ-032 With HAZ_STATS_EN defined: 70000 consecutive load-use cycles -> stall_cnt saturates at 16'hFFFF.
